// File: rtl/ws2812_pkg.sv
// rtl/ws2812_pkg.sv - shared WS2812 state encoding, default timing constants and GRB field helpers.
package ws2812_pkg;

  typedef enum logic [2:0] {
    ST_SYNC_GAP,
    ST_IDLE,
    ST_HIGH,
    ST_LOW,
    ST_ERR
  } rx_state_e;

  // Defaults in clk cycles at 100 MHz.
  localparam int unsigned WS_CLK_HZ         = 100_000_000;
  localparam int unsigned T0H_CYCLES        = 40;
  localparam int unsigned T1H_CYCLES        = 80;
  localparam int unsigned BIT_PERIOD_CYCLES = 125;
  localparam int unsigned BIT_THRESH_CYCLES = 60;
  localparam int unsigned MIN_HIGH_CYCLES   = 15;
  localparam int unsigned MAX_HIGH_CYCLES   = 120;
  localparam int unsigned RESET_GAP_CYCLES  = 5000;
  localparam int unsigned PX_NUM_DEFAULT    = 52;
  localparam int unsigned PX_COUNT_W        = 6;
  localparam int unsigned GRB_BITS          = 24;

  typedef struct packed {
    logic [7:0] g;
    logic [7:0] r;
    logic [7:0] b;
  } grb_t;

  function automatic logic [7:0] grb_green(input logic [23:0] w);
    return w[23:16];
  endfunction

  function automatic logic [7:0] grb_red(input logic [23:0] w);
    return w[15:8];
  endfunction

  function automatic logic [7:0] grb_blue(input logic [23:0] w);
    return w[7:0];
  endfunction

endpackage

// File: rtl/ws2812_rx_sync.sv
// rtl/ws2812_rx_sync.sv - two-flop synchronizer for din with registered level and rise/fall strobes.
module ws2812_rx_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta_q, sync_q, level_q, rise_q, fall_q;
  logic rise_d, fall_d;

  always_comb begin
    rise_d = sync_q & ~level_q;
    fall_d = ~sync_q & level_q;
  end

  // Level and strobes update together, so the FSM sees a consistent view 3 clk after the pin.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      meta_q  <= din;
      sync_q  <= meta_q;
      level_q <= sync_q;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/ws2812_rx.sv
// rtl/ws2812_rx.sv - WS2812 one-wire receiver: pulse classification, GRB word assembly, frame latch and errors.
module ws2812_rx
  import ws2812_pkg::*;
#(
  parameter int unsigned CLK_HZ         = WS_CLK_HZ,
  parameter int unsigned BIT_THRESH     = BIT_THRESH_CYCLES,
  parameter int unsigned MIN_HIGH       = MIN_HIGH_CYCLES,
  parameter int unsigned MAX_HIGH       = MAX_HIGH_CYCLES,
  parameter int unsigned RESET_CYCLES   = RESET_GAP_CYCLES,
  parameter int unsigned PX_NUM         = PX_NUM_DEFAULT,
  parameter int unsigned PX_COUNT_WIDTH = PX_COUNT_W,
  parameter int unsigned BITS_PER_PIXEL = GRB_BITS
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      din,
  output logic [BITS_PER_PIXEL-1:0] pixel,
  output logic                      pixel_valid,
  output logic [PX_COUNT_WIDTH-1:0] pixel_idx,
  output logic                      frame_done,
  output logic [PX_COUNT_WIDTH:0]   frame_len,
  output logic                      frame_err,
  output logic                      overflow
);

  localparam int HW  = $clog2(MAX_HIGH + 1);
  localparam int LW  = $clog2(RESET_CYCLES + 1);
  localparam int BCW = $clog2(BITS_PER_PIXEL);
  localparam int WW  = PX_COUNT_WIDTH + 1;

  localparam logic [HW-1:0]  HIGH_SAT  = HW'(MAX_HIGH);
  localparam logic [HW-1:0]  BIT_TH    = HW'(BIT_THRESH);
  localparam logic [HW-1:0]  MIN_H     = HW'(MIN_HIGH);
  localparam logic [LW-1:0]  LOW_SAT   = LW'(RESET_CYCLES);
  localparam logic [BCW-1:0] LAST_BIT  = BCW'(BITS_PER_PIXEL - 1);
  localparam logic [WW-1:0]  PX_LIMIT  = WW'(PX_NUM);
  localparam logic [WW-1:0]  WORD_SAT  = WW'(PX_NUM + 1);

  if (CLK_HZ == 0 || MIN_HIGH >= BIT_THRESH || BIT_THRESH >= MAX_HIGH) begin : g_bad_params
    $error("ws2812_rx: inconsistent timing parameters");
  end

  logic level, rise, fall;

  ws2812_rx_sync u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (din),
    .level   (level),
    .rise    (rise),
    .fall    (fall)
  );

  rx_state_e                 state_q, state_d;
  logic [HW-1:0]             high_cnt_q, high_cnt_d;
  logic [LW-1:0]             low_cnt_q, low_cnt_d;
  logic [BCW-1:0]            bit_cnt_q, bit_cnt_d;
  logic [WW-1:0]             word_cnt_q, word_cnt_d;
  logic [BITS_PER_PIXEL-2:0] shreg_q, shreg_d;
  logic [BITS_PER_PIXEL-1:0] pixel_q, pixel_d;
  logic                      pixel_valid_q, pixel_valid_d;
  logic [PX_COUNT_WIDTH-1:0] pixel_idx_q, pixel_idx_d;
  logic                      frame_done_q, frame_done_d;
  logic [WW-1:0]             frame_len_q, frame_len_d;
  logic                      frame_err_q, frame_err_d;
  logic                      overflow_q, overflow_d;

  logic [HW-1:0]             high_inc;
  logic [LW-1:0]             low_inc;
  logic                      rx_bit;
  logic [BITS_PER_PIXEL-1:0] new_word;

  always_comb begin
    state_d       = state_q;
    high_cnt_d    = high_cnt_q;
    low_cnt_d     = low_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    word_cnt_d    = word_cnt_q;
    shreg_d       = shreg_q;
    pixel_d       = pixel_q;
    pixel_valid_d = 1'b0;
    pixel_idx_d   = pixel_idx_q;
    frame_done_d  = 1'b0;
    frame_len_d   = frame_len_q;
    frame_err_d   = frame_err_q;
    overflow_d    = overflow_q;

    high_inc = (high_cnt_q == HIGH_SAT) ? high_cnt_q : high_cnt_q + 1'b1;
    low_inc  = (low_cnt_q == LOW_SAT) ? low_cnt_q : low_cnt_q + 1'b1;
    rx_bit   = (high_cnt_q >= BIT_TH);
    new_word = {shreg_q, rx_bit};

    case (state_q)
      // ERR differs from SYNC_GAP only in how it was entered (frame_err already set).
      ST_SYNC_GAP, ST_ERR: begin
        if (level) begin
          low_cnt_d = '0;
        end else if (low_inc == LOW_SAT) begin
          low_cnt_d = '0;
          state_d   = ST_IDLE;
        end else begin
          low_cnt_d = low_inc;
        end
      end

      // A level without a strobe means the rise coincided with the latch timeout.
      ST_IDLE: begin
        if (level) begin
          state_d     = ST_HIGH;
          high_cnt_d  = rise ? HW'(1) : HW'(2);
          bit_cnt_d   = '0;
          word_cnt_d  = '0;
          frame_err_d = 1'b0;
          overflow_d  = 1'b0;
        end
      end

      ST_HIGH: begin
        if (fall) begin
          low_cnt_d = '0;
          if (high_cnt_q < MIN_H) begin
            state_d     = ST_ERR;
            frame_err_d = 1'b1;
            bit_cnt_d   = '0;
          end else begin
            state_d = ST_LOW;
            shreg_d = new_word[BITS_PER_PIXEL-2:0];
            if (bit_cnt_q == LAST_BIT) begin
              bit_cnt_d = '0;
              if (word_cnt_q < PX_LIMIT) begin
                pixel_d       = new_word;
                pixel_valid_d = 1'b1;
                pixel_idx_d   = word_cnt_q[PX_COUNT_WIDTH-1:0];
              end else begin
                overflow_d = 1'b1;
              end
              if (word_cnt_q != WORD_SAT) begin
                word_cnt_d = word_cnt_q + 1'b1;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
        end else if (high_inc == HIGH_SAT) begin
          state_d     = ST_ERR;
          frame_err_d = 1'b1;
          bit_cnt_d   = '0;
          low_cnt_d   = '0;
        end else begin
          high_cnt_d = high_inc;
        end
      end

      // Latch timeout is checked before the rise strobe so a completed gap always wins.
      ST_LOW: begin
        if (low_inc == LOW_SAT) begin
          frame_done_d = 1'b1;
          frame_len_d  = word_cnt_q;
          if (bit_cnt_q != '0) begin
            frame_err_d = 1'b1;
          end
          bit_cnt_d = '0;
          low_cnt_d = '0;
          state_d   = ST_IDLE;
        end else if (rise) begin
          state_d    = ST_HIGH;
          high_cnt_d = HW'(1);
        end else begin
          low_cnt_d = low_inc;
        end
      end

      default: state_d = ST_SYNC_GAP;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_SYNC_GAP;
      high_cnt_q    <= '0;
      low_cnt_q     <= '0;
      bit_cnt_q     <= '0;
      word_cnt_q    <= '0;
      shreg_q       <= '0;
      pixel_q       <= '0;
      pixel_valid_q <= 1'b0;
      pixel_idx_q   <= '0;
      frame_done_q  <= 1'b0;
      frame_len_q   <= '0;
      frame_err_q   <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      high_cnt_q    <= high_cnt_d;
      low_cnt_q     <= low_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      word_cnt_q    <= word_cnt_d;
      shreg_q       <= shreg_d;
      pixel_q       <= pixel_d;
      pixel_valid_q <= pixel_valid_d;
      pixel_idx_q   <= pixel_idx_d;
      frame_done_q  <= frame_done_d;
      frame_len_q   <= frame_len_d;
      frame_err_q   <= frame_err_d;
      overflow_q    <= overflow_d;
    end
  end

  assign pixel       = pixel_q;
  assign pixel_valid = pixel_valid_q;
  assign pixel_idx   = pixel_idx_q;
  assign frame_done  = frame_done_q;
  assign frame_len   = frame_len_q;
  assign frame_err   = frame_err_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_ws2812_rx.sv
// tb/tb_ws2812_rx.sv - directed bench for ws2812_rx with pixel and frame scoreboards.
module tb_ws2812_rx;

  localparam int PXN = 4;
  localparam int GAP = 1200;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        din;
  logic [23:0] pixel;
  logic        pixel_valid;
  logic [5:0]  pixel_idx;
  logic        frame_done;
  logic [6:0]  frame_len;
  logic        frame_err;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  logic [29:0] exp_pix[$];
  logic [8:0]  exp_frm[$];

  always #5 clk = ~clk;

  ws2812_rx #(
    .PX_NUM       (PXN),
    .RESET_CYCLES (1000)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .din         (din),
    .pixel       (pixel),
    .pixel_valid (pixel_valid),
    .pixel_idx   (pixel_idx),
    .frame_done  (frame_done),
    .frame_len   (frame_len),
    .frame_err   (frame_err),
    .overflow    (overflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input int h, input int l);
    din = 1'b1;
    repeat (h) @(posedge clk);
    #1 din = 1'b0;
    repeat (l) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    if (b) pulse(80, 10);
    else   pulse(40, 50);
  endtask

  task automatic send_word(input logic [23:0] w);
    for (int i = 23; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic gap(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_pix(input logic [23:0] w, input int idx);
    logic [5:0] i6;
    i6 = idx[5:0];
    exp_pix.push_back({i6, w});
  endtask

  task automatic push_frm(input int len, input logic err, input logic ovf);
    logic [6:0] l7;
    l7 = len[6:0];
    exp_frm.push_back({l7, err, ovf});
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pixel"}, 32'(pixel), 32'd0);
    check({tag, "_pixel_valid"}, 32'(pixel_valid), 32'd0);
    check({tag, "_pixel_idx"}, 32'(pixel_idx), 32'd0);
    check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    check({tag, "_frame_len"}, 32'(frame_len), 32'd0);
    check({tag, "_frame_err"}, 32'(frame_err), 32'd0);
    check({tag, "_overflow"}, 32'(overflow), 32'd0);
  endtask

  always @(negedge clk) begin
    if (reset_n === 1'b1 && pixel_valid === 1'b1) begin
      if (exp_pix.size() == 0) begin
        check("unexpected_pixel_valid", 32'(pixel_valid), 32'd0);
      end else begin
        logic [29:0] e;
        e = exp_pix.pop_front();
        check("pixel", 32'(pixel), 32'(e[23:0]));
        check("pixel_idx", 32'(pixel_idx), 32'(e[29:24]));
      end
    end
    if (reset_n === 1'b1 && frame_done === 1'b1) begin
      if (exp_frm.size() == 0) begin
        check("unexpected_frame_done", 32'(frame_done), 32'd0);
      end else begin
        logic [8:0] f;
        f = exp_frm.pop_front();
        check("frame_len", 32'(frame_len), 32'(f[8:2]));
        check("frame_err", 32'(frame_err), 32'(f[1]));
        check("overflow", 32'(overflow), 32'(f[0]));
      end
    end
  end

  initial begin
    logic [19:0] tail;
    din     = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset_n = 1'b1;
    gap(GAP);

    // Full frame of identical words.
    for (int i = 0; i < PXN; i++) begin
      push_pix(24'hA5C381, i);
      send_word(24'hA5C381);
    end
    push_frm(PXN, 1'b0, 1'b0);
    gap(GAP);

    push_pix(24'h800001, 0);
    send_word(24'h800001);
    push_frm(1, 1'b0, 1'b0);
    gap(GAP);

    // Boundary highs: 59->0, 60->1, 15 (shortest legal)->0, 119 (longest legal)->1.
    tail = 20'h5A3C1;
    push_pix({4'b0101, tail}, 0);
    pulse(59, 31);
    pulse(60, 30);
    pulse(15, 75);
    pulse(119, 10);
    for (int i = 19; i >= 0; i--) send_bit(tail[i]);
    push_frm(1, 1'b0, 1'b0);
    gap(GAP);

    // Glitch mid-word: the interrupted word and the rest of the burst are dropped.
    push_pix(24'h123456, 0);
    send_word(24'h123456);
    for (int i = 0; i < 12; i++) send_bit(1'b1);
    pulse(10, 50);
    for (int i = 0; i < 5; i++) send_bit(1'b0);
    gap(GAP);
    check("frame_err_after_glitch", 32'(frame_err), 32'd1);
    push_pix(24'h00FF0F, 0);
    send_bit(1'b0);
    check("frame_err_cleared_first_bit", 32'(frame_err), 32'd0);
    for (int i = 22; i >= 0; i--) send_bit(24'h00FF0F >> i);
    push_frm(1, 1'b0, 1'b0);
    gap(GAP);

    // Short frame: trailing partial word.
    for (int i = 0; i < 3; i++) begin
      push_pix(24'h0F0F0F ^ 24'(i), i);
      send_word(24'h0F0F0F ^ 24'(i));
    end
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    push_frm(3, 1'b1, 1'b0);
    gap(GAP);

    // Overflow: PXN+2 words, frame_len saturates at PXN+1.
    for (int i = 0; i < PXN + 2; i++) begin
      if (i < PXN) push_pix(24'h010203 * 24'(i + 1), i);
      send_word(24'h010203 * 24'(i + 1));
    end
    push_frm(PXN + 1, 1'b0, 1'b1);
    gap(GAP);

    // Reset in the middle of a high pulse, then resume mid-stream.
    push_pix(24'hFEDCBA, 0);
    send_word(24'hFEDCBA);
    push_pix(24'h13579B, 1);
    send_word(24'h13579B);
    din = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("pre_reset_pixel_idx", 32'(pixel_idx), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    check_all_zero("midword_reset");
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (20) @(posedge clk);
    #1 din = 1'b0;
    gap(50);
    for (int i = 0; i < 10; i++) send_bit(1'b1);
    send_word(24'h55AA55);
    gap(GAP);
    push_pix(24'hC0FFEE, 0);
    send_word(24'hC0FFEE);
    push_frm(1, 1'b0, 1'b0);
    gap(GAP);

    check("pixel_queue_drained", 32'(exp_pix.size()), 32'd0);
    check("frame_queue_drained", 32'(exp_frm.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ws2812_rx.md
Name: ws2812_rx

Overview:
Receive-side decoder for the WS2812 one-wire stream that the strip driver emits. It samples the serial line, classifies each high pulse as bit 0 or 1, and assembles MSB-first 24-bit GRB words. It tags each word with its LED index and reports frame latch (reset gap) and protocol errors. It sits on a loopback tap of ws2812_dout (or on a daisy-chain input) for self-test and MMIO readback of what was actually driven.

Parameters:
CLK_HZ, 100000000, system clock frequency; documents the cycle constants below.
BIT_THRESH, 60, high-time in cycles at or above which a pulse decodes as 1 (T0H≈40, T1H≈80 @100 MHz).
MIN_HIGH, 15, high-time below which a pulse is a glitch (error).
MAX_HIGH, 120, high-time at which a pulse is too long (error).
RESET_CYCLES, 5000, continuous low time that constitutes a latch/reset gap (50 us).
PX_NUM, 52, LEDs per frame.
PX_COUNT_WIDTH, 6, width of pixel index.
BITS_PER_PIXEL, 24, bits per word.

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
din  input  1  raw serial line (asynchronous to clk)
pixel  output  24  last decoded word, GRB, bit 23 first received
pixel_valid  output  1  one-cycle strobe: pixel/pixel_idx valid
pixel_idx  output  PX_COUNT_WIDTH  index of word within current frame
frame_done  output  1  one-cycle strobe at latch gap after ≥1 bit received
frame_len  output  PX_COUNT_WIDTH+1  words received in the frame just latched
frame_err  output  1  sticky: error seen in current/last frame; cleared at next frame's first bit
overflow  output  1  sticky: more than PX_NUM words in frame; same clear rule

Behaviour:
- Interface: one clock clk; reset reset_n asynchronous, active-low. All outputs 0 in reset. State goes to SYNC_GAP.
- din passes a 2-flop synchronizer; edges are detected on synchronized value. Pin-to-edge latency 3 clk.
- States: SYNC_GAP, IDLE, HIGH, LOW, ERR.
- SYNC_GAP: count low cycles; any high restarts count. At RESET_CYCLES go IDLE without frame_done. Guarantees alignment after reset or mid-stream power-up.
- IDLE: rising edge → HIGH; clear high_cnt, bit_cnt, pixel_idx; clear frame_err/overflow.
- HIGH: high_cnt++ (saturating). Falling edge with high_cnt<MIN_HIGH → ERR. high_cnt reaching MAX_HIGH → ERR. Otherwise shift in bit (high_cnt≥BIT_THRESH) and go LOW with low_cnt=0.
- Bit shift: shreg <= {shreg[22:0],bit}; bit_cnt++. On the 24th bit, in the cycle after the falling edge: pixel<=shreg, pixel_valid=1, pixel_idx=current index, index++, bit_cnt=0.
- Index ≥ PX_NUM: word not emitted (no pixel_valid); overflow set; counting continues, with frame_len saturating at PX_NUM+1.
- LOW: low_cnt++. Rising edge → HIGH. No min-low check; the period is not enforced. low_cnt reaching RESET_CYCLES → frame_done=1 for one cycle, frame_len=words counted. If bit_cnt≠0 (partial word), set frame_err and discard the partial bits. Go IDLE.
- ERR: set frame_err; drop partial word; behave as SYNC_GAP (wait full low gap, no frame_done).
- Rising edge and latch timeout in the same cycle: the timeout wins (gap completed first); the edge is then handled from IDLE on the next cycle via the synchronized level.
- Counters are sized for RESET_CYCLES and saturate; they never wrap.
- pixel holds its value between strobes.

Decomposition:
- Package ws2812_pkg: state enum, default timing constants (T0H/T1H/threshold/reset cycles), GRB field slices. Shared with neopixel_controller.
- One sub-module ws2812_rx_sync: 2-flop synchronizer plus rise/fall strobes (async active-low reset, reset value 0).

Test Plan:
- Loopback from neopixel_controller driving 52 words with pixel=0xA5C381 → 52 pixel_valid strobes, idx 0..51, each 0xA5C381; then frame_done with frame_len=52, frame_err=0.
- Directed bits: highs of 40 and 80 cycles, period 125, sending 0x800001 → pixel=0x800001. Thresholds: 59 cycles→0, 60 cycles→1.
- Glitch: 10-cycle high mid-word → frame_err=1, no pixel_valid for that word, no frame_done. After a 5000-cycle gap the next frame decodes normally and frame_err clears on its first bit.
- Short frame: 3 words + 5 bits then 5000 low → 3 strobes, frame_done, frame_len=3, frame_err=1.
- Overflow: 54 words → 52 strobes, overflow=1, frame_len=53 (saturated).
- reset_n asserted mid-word → all outputs 0 immediately. After release, stream resumes mid-frame: nothing emitted until a 5000-cycle low gap, then the next frame decodes from idx 0.
